iq_capture_scheduler: RTL and testbench

- Sequences IQ sample writes into the double-banked (ping-pong) IQ BRAM, framed by the one-second marker.
- Sits between the CIC decimator strobe / one_sec_marker and the IQBRAM write port.
- Owns bank selection, write address, transmit inhibit and sample-count saturation.
- Hands completed one-second frames to the PS readout with a ready/ack handshake and overrun detection.

---
 rtl/iq_capture_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_iq_capture_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/iq_capture_scheduler.sv
// iq_capture_scheduler
// Drives the write port of the ping-pong IQ BRAM. Decimated IQ strobes are
// turned into one-cycle writes into the active bank. The one-second marker
// closes the active bank and hands it to the PS as a frame.
// Bank select, sample address, transmit inhibit, sample-count saturation and
// the PS ready/ack handshake with overrun detection all live here.

module iq_capture_scheduler #(
    parameter int ADDR_WIDTH  = 16,
    parameter int MAX_SAMPLES = 40960
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cic_40_pulse,
    input  logic                  one_sec_pulse,
    input  logic                  tx_high,
    input  logic                  frame_ack,
    output logic [ADDR_WIDTH:0]   bram_addr,
    output logic [3:0]            bram_we,
    output logic                  frame_ready,
    output logic                  frame_bank,
    output logic [ADDR_WIDTH:0]   frame_count,
    output logic                  frame_full,
    output logic                  overrun,
    output logic                  state_sync
);

    // The count has one more bit than the address, so a bank that is
    // completely full (MAX_SAMPLES == 2**ADDR_WIDTH) still fits in it.
    localparam logic [ADDR_WIDTH:0] C_MAX_COUNT = MAX_SAMPLES[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] C_CNT_ONE   = 1;

    typedef enum logic {
        ST_WAIT_SYNC = 1'b0,
        ST_CAPTURE   = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                  r_state;
    logic                    r_sec_d;
    logic                    r_bank;
    logic [ADDR_WIDTH:0]     r_count;
    logic                    r_full;
    logic [ADDR_WIDTH:0]     r_bram_addr;
    logic [3:0]              r_bram_we;
    logic                    r_frame_ready;
    logic                    r_frame_bank;
    logic [ADDR_WIDTH:0]     r_frame_count;
    logic                    r_frame_full;
    logic                    r_overrun;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    state_t                  w_state_next;
    logic                    w_sec_edge;
    logic                    w_sync_start;
    logic                    w_close;
    logic                    w_accept;
    logic                    w_drop;
    logic                    w_wr_bank;
    logic [ADDR_WIDTH-1:0]   w_wr_idx;

    assign w_sec_edge = one_sec_pulse & ~r_sec_d;

    // The marker history register runs even during reset so that a marker
    // already high when reset releases is not seen as a fresh edge.
    always_ff @(posedge clk) begin
        // NOTE: every clocked assignment is non-blocking so that all
        // registers update together from values sampled before the edge.
        r_sec_d <= one_sec_pulse;
    end

    // Next-state and per-cycle decisions: sync, frame close, write or drop.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves one unassigned, which would infer a latch.
        w_state_next = r_state;
        w_sync_start = 1'b0;
        w_close      = 1'b0;
        w_accept     = 1'b0;
        w_drop       = 1'b0;
        w_wr_bank    = r_bank;
        w_wr_idx     = r_count[ADDR_WIDTH-1:0];

        case (r_state)
            ST_WAIT_SYNC: begin
                // Strobes are ignored until the first marker edge aligns us.
                if (w_sec_edge) begin
                    w_state_next = ST_CAPTURE;
                    w_sync_start = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (w_sec_edge) begin
                    w_close = 1'b1;
                    // A strobe landing on the marker is sample 0 of the
                    // bank being opened.
                    if (cic_40_pulse) begin
                        w_accept  = 1'b1;
                        w_wr_bank = ~r_bank;
                        w_wr_idx  = '0;
                    end
                end else if (cic_40_pulse) begin
                    if (r_count < C_MAX_COUNT) begin
                        w_accept = 1'b1;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_WAIT_SYNC;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_WAIT_SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Active-bank bookkeeping and the BRAM write port. A tx-inhibited strobe
    // still uses up an address so that sample timing within the second stays
    // aligned; only the byte enables are suppressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bank      <= 1'b0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_bram_addr <= '0;
            r_bram_we   <= 4'h0;
        end else begin
            r_bram_we <= 4'h0;

            if (w_sync_start) begin
                r_bank  <= 1'b0;
                r_count <= '0;
                r_full  <= 1'b0;
            end else if (w_close) begin
                r_bank  <= ~r_bank;
                r_count <= w_accept ? C_CNT_ONE : '0;
                r_full  <= 1'b0;
            end else if (w_accept) begin
                r_count <= r_count + C_CNT_ONE;
            end else if (w_drop) begin
                r_full <= 1'b1;
            end

            if (w_accept) begin
                r_bram_addr <= {w_wr_bank, w_wr_idx};
                r_bram_we   <= tx_high ? 4'h0 : 4'hF;
            end
        end
    end

    // Frame handoff to the PS. A close always publishes the finished bank;
    // if the previous frame was still unacknowledged it is overwritten and
    // the sticky overrun flag records the loss. An ack arriving with a close
    // counts as consuming the old frame, so no overrun is raised.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_ready <= 1'b0;
            r_frame_bank  <= 1'b0;
            r_frame_count <= '0;
            r_frame_full  <= 1'b0;
            r_overrun     <= 1'b0;
        end else if (w_close) begin
            r_frame_ready <= 1'b1;
            r_frame_bank  <= r_bank;
            r_frame_count <= r_count;
            r_frame_full  <= r_full;
            if (r_frame_ready && !frame_ack) begin
                r_overrun <= 1'b1;
            end
        end else if (r_frame_ready && frame_ack) begin
            r_frame_ready <= 1'b0;
        end
    end

    assign bram_addr   = r_bram_addr;
    assign bram_we     = r_bram_we;
    assign frame_ready = r_frame_ready;
    assign frame_bank  = r_frame_bank;
    assign frame_count = r_frame_count;
    assign frame_full  = r_frame_full;
    assign overrun     = r_overrun;
    assign state_sync  = (r_state == ST_CAPTURE);

endmodule

// File: tb/tb_iq_capture_scheduler.sv
// Testbench for iq_capture_scheduler with ADDR_WIDTH=3, MAX_SAMPLES=8.
// Stimulus pushes each expected BRAM write (address and cycle) into a queue.
// A monitor pops and compares whenever the DUT raises bram_we. Frame
// handshake status is compared directly after the relevant cycles.

module tb_iq_capture_scheduler;

    localparam int AW  = 3;
    localparam int MAX = 8;

    logic          clk;
    logic          rst;
    logic          cic_40_pulse;
    logic          one_sec_pulse;
    logic          tx_high;
    logic          frame_ack;
    logic [AW:0]   bram_addr;
    logic [3:0]    bram_we;
    logic          frame_ready;
    logic          frame_bank;
    logic [AW:0]   frame_count;
    logic          frame_full;
    logic          overrun;
    logic          state_sync;

    iq_capture_scheduler #(
        .ADDR_WIDTH  (AW),
        .MAX_SAMPLES (MAX)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cic_40_pulse  (cic_40_pulse),
        .one_sec_pulse (one_sec_pulse),
        .tx_high       (tx_high),
        .frame_ack     (frame_ack),
        .bram_addr     (bram_addr),
        .bram_we       (bram_we),
        .frame_ready   (frame_ready),
        .frame_bank    (frame_bank),
        .frame_count   (frame_count),
        .frame_full    (frame_full),
        .overrun       (overrun),
        .state_sync    (state_sync)
    );

    typedef struct {
        int          cyc;
        logic [AW:0] addr;
    } exp_wr_t;

    exp_wr_t exp_q[$];
    exp_wr_t mon_e;
    int      cyc;
    int      n_checks;
    int      n_fail;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic rdy, input logic bnk,
                                input int cnt, input logic full, input logic ov,
                                input logic sync);
        check({tag, ".frame_ready"}, 32'(frame_ready), 32'(rdy));
        check({tag, ".frame_bank"},  32'(frame_bank),  32'(bnk));
        check({tag, ".frame_count"}, 32'(frame_count), 32'(cnt));
        check({tag, ".frame_full"},  32'(frame_full),  32'(full));
        check({tag, ".overrun"},     32'(overrun),     32'(ov));
        check({tag, ".state_sync"},  32'(state_sync),  32'(sync));
    endtask

    // Apply one cycle of inputs; if a write is expected, it must appear on
    // the port in the following cycle at exp_addr.
    task automatic drive(input logic cic, input logic sec, input logic tx, input logic ack,
                         input logic exp_wr, input logic [AW:0] exp_addr);
        exp_wr_t e;
        cic_40_pulse  = cic;
        one_sec_pulse = sec;
        tx_high       = tx;
        frame_ack     = ack;
        if (exp_wr) begin
            e.cyc  = cyc + 1;
            e.addr = exp_addr;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cic_40_pulse  = 1'b0;
        one_sec_pulse = 1'b0;
        tx_high       = 1'b0;
        frame_ack     = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic sec_edge(input logic ack);
        drive(1'b0, 1'b1, 1'b0, ack, 1'b0, '0);
    endtask

    // Write-port monitor.
    always @(negedge clk) begin
        if (bram_we !== 4'h0) begin
            if (bram_we !== 4'hF) check("wr_we_value", 32'(bram_we), 32'hF);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr=%0h we=%0h cycle=%0d, none expected",
                         bram_addr, bram_we, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr",  32'(bram_addr), 32'(mon_e.addr));
                check("wr_cycle", 32'(cyc),       32'(mon_e.cyc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        cic_40_pulse  = 1'b0;
        one_sec_pulse = 1'b0;
        tx_high       = 1'b0;
        frame_ack     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_status("reset", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("reset.bram_we",   32'(bram_we),   32'h0);
        check("reset.bram_addr", 32'(bram_addr), 32'h0);
        rst = 1'b0;

        // Strobes before any marker are ignored.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
            idle();
        end
        check_status("t1", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // First marker syncs without a frame; five writes to bank 0.
        sec_edge(1'b0);
        check_status("t2.sync", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'(i));
            idle();
        end
        idle();
        check("t2.addr_hold", 32'(bram_addr), 32'h4);
        sec_edge(1'b0);
        check_status("t2.close", 1'b1, 1'b0, 5, 1'b0, 1'b0, 1'b1);

        // Bank 1: slots 1 and 2 inhibited by tx_high but still counted.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h8);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'hB);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'hC);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        check_status("t3.ack", 1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        check_status("t3.ack_idle", 1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b1);
        sec_edge(1'b0);
        check_status("t3.close", 1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        check_status("t3.ack2", 1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b1);

        // Bank 0: eleven back-to-back strobes saturate at 8.
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, (i < 8), 4'(i));
        end
        idle();
        sec_edge(1'b0);
        check_status("t4.close", 1'b1, 1'b0, 8, 1'b1, 1'b0, 1'b1);

        // Ack coincident with marker: new frame published, no overrun.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h8);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h9);
        sec_edge(1'b1);
        check_status("t5.edge_ack", 1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b1);
        idle();
        sec_edge(1'b0);
        check_status("t5.overrun", 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        check_status("t5.ack", 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1);

        // Strobe coincident with marker lands at {new bank, 0}.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h8);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
        check_status("t6.coincident", 1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2);

        // Reset mid-frame with a strobe in the same cycle: no write.
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check_status("t6.reset", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("t6.reset.bram_we",   32'(bram_we),   32'h0);
        check("t6.reset.bram_addr", 32'(bram_addr), 32'h0);
        rst = 1'b0;

        // Must resynchronise before writing again.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("t6.resync_wait", 32'(state_sync), 32'h0);
        sec_edge(1'b0);
        check("t6.resync", 32'(state_sync), 32'h1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
        idle();
        idle();

        check("pending_writes", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
